// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default constants for the pulse train generator.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  localparam int unsigned DefWidth      = 8;
  localparam int unsigned DefHighCycles = 1;
  localparam int unsigned DefLowCycles  = 1;

  // Timer must hold the longer of the two phase lengths.
  function automatic int unsigned timer_width(int unsigned high_cycles, int unsigned low_cycles);
    return $clog2(((high_cycles > low_cycles) ? high_cycles : low_cycles) + 1);
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter; tc_o flags the last cycle of the loaded phase.
module pulse_train_gen_phase_timer
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign tc_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Burst generator: emits exactly in_count pulses with a start/busy/done handshake.
// Optional abort input enabled by defining PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned HIGH_CYCLES = DefHighCycles,
  parameter int unsigned LOW_CYCLES  = DefLowCycles
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_count,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic             in_abort,
`endif
  output logic             out_pulse,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_remaining
);

  localparam int unsigned TimerW = timer_width(HIGH_CYCLES, LOW_CYCLES);

  state_e            state_q;
  logic [WIDTH-1:0]  remaining_q;
  logic              pulse_q, busy_q, done_q;
  logic              timer_load, timer_dec, timer_tc;
  logic [TimerW-1:0] timer_load_val;

  // Timer reloads on every entry into HIGH or LOW.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = TimerW'(HIGH_CYCLES);
    unique case (state_q)
      StIdle: timer_load = in_start && (in_count != '0);
      StHigh: begin
        if (timer_tc) begin
          timer_load     = 1'b1;
          timer_load_val = TimerW'(LOW_CYCLES);
        end
      end
      StLow:  timer_load = timer_tc && (remaining_q != '0);
      StDone: ;
    endcase
  end

  assign timer_dec = (state_q == StHigh) || (state_q == StLow);

  pulse_train_gen_phase_timer #(
    .Width(TimerW)
  ) u_phase_timer (
    .clk_i      (in_clock),
    .rst_i      (in_reset),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .dec_i      (timer_dec),
    .tc_o       (timer_tc)
  );

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic abort_hit;
  // An abort landing on the final LOW cycle of the burst is just normal completion.
  assign abort_hit = in_abort && busy_q &&
                     !((state_q == StLow) && timer_tc && (remaining_q == '0));
`endif

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    if (abort_hit) begin
      state_q <= StIdle;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
    end else
`endif
    begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_start) begin
            remaining_q <= in_count;
            if (in_count != '0) begin
              state_q <= StHigh;
              pulse_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StHigh: begin
          if (timer_tc) begin
            remaining_q <= remaining_q - WIDTH'(1);
            state_q     <= StLow;
            pulse_q     <= 1'b0;
          end
        end
        StLow: begin
          if (timer_tc) begin
            if (remaining_q != '0) begin
              state_q <= StHigh;
              pulse_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_pulse     = pulse_q;
  assign out_busy      = busy_q;
  assign out_done      = done_q;
  assign out_remaining = remaining_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: two instances (H1/L1 and H2/L3).
module tb_pulse_train_gen;

  typedef struct {
    int pulses;
    int busy;
    int rem;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1, rst2, start1, start2;
  logic [7:0] cnt1, cnt2;
  logic       pulse1, busy1, done1, pulse2, busy2, done2;
  logic [7:0] rem1, rem2;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic       abort1;
  logic       abort2;
`endif

  int checks   = 0;
  int failures = 0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  pulse_train_gen u_dut1 (
    .in_clock      (clk),
    .in_reset      (rst1),
    .in_start      (start1),
    .in_count      (cnt1),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .in_abort      (abort1),
`endif
    .out_pulse     (pulse1),
    .out_busy      (busy1),
    .out_done      (done1),
    .out_remaining (rem1)
  );

  pulse_train_gen #(
    .WIDTH       (8),
    .HIGH_CYCLES (2),
    .LOW_CYCLES  (3)
  ) u_dut2 (
    .in_clock      (clk),
    .in_reset      (rst2),
    .in_start      (start2),
    .in_count      (cnt2),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .in_abort      (abort2),
`endif
    .out_pulse     (pulse2),
    .out_busy      (busy2),
    .out_done      (done2),
    .out_remaining (rem2)
  );

  function automatic exp_t mk(int p, int b, int r);
    exp_t e;
    e.pulses = p;
    e.busy   = b;
    e.rem    = r;
    return e;
  endfunction

  // Monitors: count pulses and busy cycles like the edge counter would, compare on out_done.
  int  pc1 = 0, bc1 = 0, pc2 = 0, bc2 = 0;
  logic pp1 = 1'b0, pp2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst1) begin
      pc1 = 0; bc1 = 0; pp1 = 1'b0;
    end else begin
      if (pulse1 && !pp1) pc1++;
      pp1 = pulse1;
      if (busy1) bc1++;
      if (done1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL dut1_unexpected_done: got done with pulses=%0d, expected no done", pc1);
        end else begin
          e = q1.pop_front();
          if (pc1 != e.pulses || bc1 != e.busy || int'(rem1) != e.rem || busy1 || pulse1) begin
            failures++;
            $display("FAIL dut1_burst: got pulses=%0d busy=%0d rem=%0d out_busy=%0b out_pulse=%0b, expected pulses=%0d busy=%0d rem=%0d out_busy=0 out_pulse=0",
                     pc1, bc1, rem1, busy1, pulse1, e.pulses, e.busy, e.rem);
          end
        end
        pc1 = 0; bc1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst2) begin
      pc2 = 0; bc2 = 0; pp2 = 1'b0;
    end else begin
      if (pulse2 && !pp2) pc2++;
      pp2 = pulse2;
      if (busy2) bc2++;
      if (done2) begin
        checks++;
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL dut2_unexpected_done: got done with pulses=%0d, expected no done", pc2);
        end else begin
          e = q2.pop_front();
          if (pc2 != e.pulses || bc2 != e.busy || int'(rem2) != e.rem || busy2 || pulse2) begin
            failures++;
            $display("FAIL dut2_burst: got pulses=%0d busy=%0d rem=%0d out_busy=%0b out_pulse=%0b, expected pulses=%0d busy=%0d rem=%0d out_busy=0 out_pulse=0",
                     pc2, bc2, rem2, busy2, pulse2, e.pulses, e.busy, e.rem);
          end
        end
        pc2 = 0; bc2 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int sel, input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel == 1) ? done1 : done2) break;
      tick();
    end
    chk(name, int'((sel == 1) ? done1 : done2), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Cycle-by-cycle expectations for count=3, H=1, L=1 (cycles 1..8 after start).
  int ep[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
  int eb[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  int ed[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int er[8] = '{3, 2, 2, 1, 1, 0, 0, 0};

  initial begin
    int n;
    logic prev;
    rst1 = 1'b1; rst2 = 1'b1;
    start1 = 1'b0; start2 = 1'b0;
    cnt1 = '0; cnt2 = '0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort1 = 1'b0;
    abort2 = 1'b0;
`endif
    tick();
    tick();
    chk("reset_pulse", int'(pulse1), 0);
    chk("reset_busy", int'(busy1), 0);
    chk("reset_done", int'(done1), 0);
    chk("reset_remaining", int'(rem1), 0);
    chk("reset2_busy", int'(busy2), 0);
    chk("reset2_remaining", int'(rem2), 0);
    rst1 = 1'b0; rst2 = 1'b0;
    tick();

    // Basic burst, count=3
    q1.push_back(mk(3, 6, 0));
    start1 = 1'b1; cnt1 = 8'd3;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start1 = 1'b0;
      chk($sformatf("basic_pulse_c%0d", c), int'(pulse1), ep[c-1]);
      chk($sformatf("basic_busy_c%0d", c), int'(busy1), eb[c-1]);
      chk($sformatf("basic_done_c%0d", c), int'(done1), ed[c-1]);
      chk($sformatf("basic_rem_c%0d", c), int'(rem1), er[c-1]);
    end

    // Zero count
    q1.push_back(mk(0, 0, 0));
    start1 = 1'b1; cnt1 = 8'd0;
    tick();
    start1 = 1'b0;
    chk("zero_busy_c1", int'(busy1), 0);
    chk("zero_done_c1", int'(done1), 0);
    chk("zero_pulse_c1", int'(pulse1), 0);
    tick();
    chk("zero_done_c2", int'(done1), 1);
    chk("zero_busy_c2", int'(busy1), 0);
    tick();

    // Start while busy is ignored; start in the done cycle is accepted
    q1.push_back(mk(2, 4, 0));
    q1.push_back(mk(2, 4, 0));
    start1 = 1'b1; cnt1 = 8'd2;
    tick();
    start1 = 1'b0;
    tick();
    start1 = 1'b1; cnt1 = 8'd5;
    tick();
    start1 = 1'b0; cnt1 = 8'd0;
    wait_done(1, "b2b_first_done", 20);
    start1 = 1'b1; cnt1 = 8'd2;
    tick();
    start1 = 1'b0;
    chk("b2b_second_busy", int'(busy1), 1);
    chk("b2b_second_rem", int'(rem1), 2);
    wait_done(1, "b2b_second_done", 20);
    tick();

    // Maximum count on H=2/L=3 instance
    q2.push_back(mk(255, 1275, 0));
    start2 = 1'b1; cnt2 = 8'd255;
    tick();
    start2 = 1'b0;
    chk("max_latency_pulse", int'(pulse2), 1);
    chk("max_latency_busy", int'(busy2), 1);
    chk("max_start_rem", int'(rem2), 255);
    wait_done(2, "max_done", 1400);
    tick();

    // Reset during pulse 10 aborts with no done
    start2 = 1'b1; cnt2 = 8'd50;
    tick();
    start2 = 1'b0;
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pulse2 && !prev) n++;
      prev = pulse2;
      if (n == 10) break;
      tick();
    end
    chk("midreset_reached_pulse10", n, 10);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("midreset_pulse", int'(pulse2), 0);
    chk("midreset_busy", int'(busy2), 0);
    chk("midreset_done", int'(done2), 0);
    chk("midreset_remaining", int'(rem2), 0);
    repeat (20) tick();
    chk("midreset_still_idle", int'(busy2), 0);

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    // Abort after pulse 3 of 8
    q1.push_back(mk(3, 6, 5));
    start1 = 1'b1; cnt1 = 8'd8;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    chk("abort_pre_rem", int'(rem1), 5);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_pulse", int'(pulse1), 0);
    chk("abort_done", int'(done1), 1);
    chk("abort_busy", int'(busy1), 0);
    chk("abort_rem", int'(rem1), 5);
    tick();
    chk("abort_done_single", int'(done1), 0);
    chk("abort_rem_frozen", int'(rem1), 5);
`endif

    tick();
    chk("dut1_queue_drained", q1.size(), 0);
    chk("dut2_queue_drained", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
